// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and default timing constants for the ultrasonic ranging chain
// (ranger front end, moving-average smoother, LED bar stage).
package ultrasonic_ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int unsigned DEF_CLK_PER_US = 40;
    localparam int unsigned DEF_TRIG_US    = 20;
    localparam int unsigned DEF_PERIOD_US  = 60000;
    localparam int unsigned DEF_MAX_US     = 3552;
    localparam int unsigned DEF_W          = 12;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side and sample-side signals of the ranger; master is the ranger itself.
interface ultrasonic_ranger_if #(
    parameter int unsigned W = ultrasonic_ranger_pkg::DEF_W
);
    logic         enable;
    logic         echo;
    logic         trig;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic         timeout;
    logic         busy;

    modport master (
        input  enable, echo,
        output trig, sample, sample_valid, timeout, busy
    );

    modport slave (
        output enable, echo,
        input  trig, sample, sample_valid, timeout, busy
    );
endinterface

// File: rtl/ultrasonic_ranger_sync_edge.sv
// Two-flop synchronizer for the raw echo pin, plus a delay stage and
// registered rise/fall strobes aligned with the delayed level.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front end: periodic trigger, echo width timing in microseconds,
// one sample per period with timeout flag for missing or saturated echoes.
module ultrasonic_ranger #(
    parameter int unsigned CLK_PER_US = ultrasonic_ranger_pkg::DEF_CLK_PER_US,
    parameter int unsigned TRIG_US    = ultrasonic_ranger_pkg::DEF_TRIG_US,
    parameter int unsigned PERIOD_US  = ultrasonic_ranger_pkg::DEF_PERIOD_US,
    parameter int unsigned MAX_US     = ultrasonic_ranger_pkg::DEF_MAX_US,
    parameter int unsigned W          = ultrasonic_ranger_pkg::DEF_W
) (
    input logic                 clk,
    input logic                 reset,
    ultrasonic_ranger_if.master bus
);
    import ultrasonic_ranger_pkg::*;

    localparam int unsigned PSW = cnt_w(CLK_PER_US);
    localparam int unsigned PCW = cnt_w(PERIOD_US);
    localparam int unsigned EW  = cnt_w(MAX_US + 1);

    state_t         state;
    logic [PSW-1:0] presc;
    logic [PCW-1:0] pcount;
    logic [EW-1:0]  ecount;
    logic           tick;
    logic           period_end;
    logic           echo_lvl;
    logic           echo_rise;
    logic           echo_fall;

    sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.echo),
        .level (echo_lvl),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    // Free-running microsecond prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    assign tick       = (presc == PSW'(CLK_PER_US - 1));
    assign period_end = tick && (pcount == PCW'(PERIOD_US - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pcount           <= '0;
            ecount           <= '0;
            bus.trig         <= 1'b0;
            bus.sample       <= '0;
            bus.sample_valid <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            if (tick && state != IDLE) pcount <= pcount + 1'b1;

            case (state)
                IDLE: begin
                    if (tick && bus.enable) begin
                        state    <= TRIG;
                        bus.trig <= 1'b1;
                        bus.busy <= 1'b1;
                        pcount   <= '0;
                    end
                end

                TRIG: begin
                    if (tick && pcount == PCW'(TRIG_US - 1)) begin
                        bus.trig <= 1'b0;
                        state    <= WAIT_ECHO;
                    end
                end

                WAIT_ECHO, MEASURE: begin
                    if (state == WAIT_ECHO) ecount <= '0;
                    if (state == MEASURE && echo_fall) begin
                        bus.sample       <= W'(ecount);
                        bus.timeout      <= 1'b0;
                        bus.sample_valid <= 1'b1;
                        state            <= HOLDOFF;
                    end else if (period_end) begin
                        // No usable echo this period: flag it and roll straight into the next one.
                        bus.sample       <= W'(MAX_US);
                        bus.timeout      <= 1'b1;
                        bus.sample_valid <= 1'b1;
                        state            <= bus.enable ? TRIG : IDLE;
                        bus.trig         <= bus.enable;
                        bus.busy         <= bus.enable;
                        pcount           <= '0;
                    end else if (state == WAIT_ECHO) begin
                        if (echo_rise) state <= MEASURE;
                    end else if (tick && echo_lvl) begin
                        if (ecount == EW'(MAX_US - 1)) begin
                            ecount           <= EW'(MAX_US);
                            bus.sample       <= W'(MAX_US);
                            bus.timeout      <= 1'b1;
                            bus.sample_valid <= 1'b1;
                            state            <= HOLDOFF;
                        end else begin
                            ecount <= ecount + 1'b1;
                        end
                    end
                end

                HOLDOFF: begin
                    if (period_end) begin
                        state    <= bus.enable ? TRIG : IDLE;
                        bus.trig <= bus.enable;
                        bus.busy <= bus.enable;
                        pcount   <= '0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.trig <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed plus randomized bench for ultrasonic_ranger with a pulse-width
// reference model (expected sample derived from the echo width in us).
module tb_ultrasonic_ranger;
    localparam int unsigned CPU = 4;
    localparam int unsigned TUS = 3;
    localparam int unsigned PUS = 100;
    localparam int unsigned MUS = 60;
    localparam int unsigned WW  = 12;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   nvalid = 0;
    int   v0 = 0;
    int   cyc = 0;
    int   last_rise = 0;

    always #5 clk = ~clk;

    ultrasonic_ranger_if #(.W(WW)) bus ();

    ultrasonic_ranger #(
        .CLK_PER_US (CPU),
        .TRIG_US    (TUS),
        .PERIOD_US  (PUS),
        .MAX_US     (MUS),
        .W          (WW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.sample_valid === 1'b1) nvalid = nvalid + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        total++;
        assert (obs >= 32'(lo) && obs <= 32'(hi)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_trig(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.trig === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Runs from just after a trigger rise to just after the next one; w=0 leaves echo alone.
    task automatic do_period(input int d, input int w, output bit ok, output int plen,
                             output int nv, output logic va);
        bit o1;
        bit o2;
        wait_trig(1'b0, 40, o1);
        if (w > 0) begin
            repeat (d * CPU) @(negedge clk);
            bus.echo = 1'b1;
            repeat (w * CPU) @(negedge clk);
            bus.echo = 1'b0;
        end
        wait_trig(1'b1, 600, o2);
        plen      = cyc - last_rise;
        last_rise = cyc;
        va        = bus.sample_valid;
        @(negedge clk);
        #1;
        nv = nvalid - v0;
        v0 = nvalid;
        ok = o1 & o2;
    endtask

    // Reference model: echo width in us maps to a clamped sample and timeout flag.
    function automatic int model_lo(input int w);
        return (w >= int'(MUS)) ? int'(MUS) : w - 1;
    endfunction
    function automatic int model_hi(input int w);
        return (w >= int'(MUS)) ? int'(MUS) : w + 1;
    endfunction
    function automatic logic model_to(input int w);
        return (w >= int'(MUS));
    endfunction

    initial begin
        bit   ok;
        int   plen;
        int   nv;
        logic va;
        int   d;
        int   w;
        bit   seen;

        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.echo   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", 32'(bus.trig), 0);
        check("rst_sample", 32'(bus.sample), 0);
        check("rst_valid", 32'(bus.sample_valid), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_busy", 32'(bus.busy), 0);

        @(negedge clk);
        reset      = 1'b0;
        bus.enable = 1'b1;
        wait_trig(1'b1, 20, ok);
        check("first_trig", 32'(ok), 1);
        last_rise = cyc;
        check("busy_on", 32'(bus.busy), 1);
        @(negedge clk);
        #1;
        v0 = nvalid;

        // 25 us echo 5 us after trigger, with exact valid latency from the falling edge
        wait_trig(1'b0, 40, ok);
        check("trig_width", 32'(cyc - last_rise), 32'(TUS * CPU));
        repeat (5 * CPU) @(negedge clk);
        bus.echo = 1'b1;
        repeat (25 * CPU) @(negedge clk);
        bus.echo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("lat_early", 32'(bus.sample_valid), 0);
        end
        @(posedge clk);
        #1;
        check("lat_valid", 32'(bus.sample_valid), 1);
        check_rng("w25_sample", 32'(bus.sample), 24, 26);
        check("w25_timeout", 32'(bus.timeout), 0);
        wait_trig(1'b1, 600, ok);
        check("period_len", 32'(cyc - last_rise), 32'(PUS * CPU));
        last_rise = cyc;
        @(negedge clk);
        #1;
        check("w25_one_valid", 32'(nvalid - v0), 1);
        v0 = nvalid;

        // no echo at all
        do_period(0, 0, ok, plen, nv, va);
        check("noecho_ok", 32'(ok), 1);
        check("noecho_plen", 32'(plen), 32'(PUS * CPU));
        check("noecho_valid_at_trig", 32'(va), 1);
        check("noecho_nv", 32'(nv), 1);
        check("noecho_sample", 32'(bus.sample), 32'(MUS));
        check("noecho_timeout", 32'(bus.timeout), 1);

        // 80 us echo saturates; late fall ignored
        do_period(5, 80, ok, plen, nv, va);
        check("w80_nv", 32'(nv), 1);
        check("w80_valid_at_trig", 32'(va), 0);
        check("w80_sample", 32'(bus.sample), 32'(MUS));
        check("w80_timeout", 32'(bus.timeout), 1);

        // randomized widths against the model
        for (int k = 0; k < 8; k++) begin
            d = int'($urandom_range(1, 10));
            if ($urandom_range(0, 2) == 0) w = int'($urandom_range(65, 85));
            else                           w = int'($urandom_range(2, 55));
            do_period(d, w, ok, plen, nv, va);
            check("rnd_ok", 32'(ok), 1);
            check("rnd_nv", 32'(nv), 1);
            check_rng("rnd_sample", 32'(bus.sample), model_lo(w), model_hi(w));
            check("rnd_timeout", 32'(bus.timeout), 32'(model_to(w)));
        end

        // echo stuck high from reset onward
        reset    = 1'b1;
        bus.echo = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_trig(1'b1, 20, ok);
        check("stuck_trig", 32'(ok), 1);
        last_rise = cyc;
        @(negedge clk);
        #1;
        v0 = nvalid;
        for (int k = 0; k < 2; k++) begin
            do_period(0, 0, ok, plen, nv, va);
            check("stuck_valid_at_trig", 32'(va), 1);
            check("stuck_nv", 32'(nv), 1);
            check("stuck_sample", 32'(bus.sample), 32'(MUS));
            check("stuck_timeout", 32'(bus.timeout), 1);
        end
        bus.echo = 1'b0;
        do_period(0, 0, ok, plen, nv, va);
        check("release_sample", 32'(bus.sample), 32'(MUS));
        check("release_timeout", 32'(bus.timeout), 1);
        do_period(4, 10, ok, plen, nv, va);
        check("w10_nv", 32'(nv), 1);
        check_rng("w10_sample", 32'(bus.sample), 9, 11);
        check("w10_timeout", 32'(bus.timeout), 0);

        // reset in the middle of a measurement
        wait_trig(1'b0, 40, ok);
        repeat (5 * CPU) @(negedge clk);
        bus.echo = 1'b1;
        repeat (10 * CPU) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_trig", 32'(bus.trig), 0);
        check("midrst_sample", 32'(bus.sample), 0);
        check("midrst_valid", 32'(bus.sample_valid), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_timeout", 32'(bus.timeout), 0);
        bus.echo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // enable dropped while the echo is high: finish this sample, then idle
        wait_trig(1'b1, 20, ok);
        check("en_trig", 32'(ok), 1);
        @(negedge clk);
        #1;
        v0 = nvalid;
        wait_trig(1'b0, 40, ok);
        repeat (5 * CPU) @(negedge clk);
        bus.echo   = 1'b1;
        bus.enable = 1'b0;
        repeat (20 * CPU) @(negedge clk);
        bus.echo = 1'b0;
        seen = 1'b0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (bus.trig === 1'b1) seen = 1'b1;
        end
        check("en_no_trig", 32'(seen), 0);
        check("en_nv", 32'(nvalid - v0), 1);
        check_rng("en_sample", 32'(bus.sample), 19, 21);
        check("en_timeout", 32'(bus.timeout), 0);
        check("en_idle_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
